// File: rtl/iq_pkg.sv
// iq_pkg: shared entry layout and constants for the issue queue
// and the functional unit it feeds.
package iq_pkg;

    localparam int ENTRY_W = 139;
    localparam int TAG_W   = 6;

    localparam logic [TAG_W-1:0] PHYS_ZERO = '0;

    localparam int F3_MSB   = 138;
    localparam int F3_LSB   = 136;
    localparam int F7_MSB   = 135;
    localparam int F7_LSB   = 129;
    localparam int OPC_MSB  = 128;
    localparam int OPC_LSB  = 122;
    localparam int RD_MSB   = 121;
    localparam int RD_LSB   = 116;
    localparam int RS1_MSB  = 115;
    localparam int RS1_LSB  = 110;
    localparam int RS1V_MSB = 109;
    localparam int RS1V_LSB = 78;
    localparam int RS2_MSB  = 77;
    localparam int RS2_LSB  = 72;
    localparam int RS2V_MSB = 71;
    localparam int RS2V_LSB = 40;
    localparam int IMM_MSB  = 39;
    localparam int IMM_LSB  = 8;
    localparam int ROB_MSB  = 7;
    localparam int ROB_LSB  = 2;
    localparam int FU_MSB   = 1;
    localparam int FU_LSB   = 0;

endpackage

// File: rtl/iq_select.sv
// iq_select: lowest-index priority encoder over the ready
// request vector; slot 0 is the oldest entry.
module iq_select #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top so the lowest set bit is the last writer.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// issue_queue: collapsing in-order-age queue with CDB wakeup,
// oldest-ready select and a registered issue port.
module issue_queue
    import iq_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               dispatch_valid,
    input  logic [ENTRY_W-1:0] dispatch_entry,
    input  logic               dispatch_rs1_ready,
    input  logic               dispatch_rs2_ready,
    output logic               dispatch_ready,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [31:0]        cdb_value,
    input  logic               issue_stall,
    output logic               issue_valid,
    output logic [ENTRY_W-1:0] issue_entry,
    output logic [CNT_W-1:0]   occupancy
);

    logic [DEPTH-1:0]              vld_q, vld_d;
    logic [DEPTH-1:0]              r1_q, r1_d;
    logic [DEPTH-1:0]              r2_q, r2_d;
    logic [DEPTH-1:0][ENTRY_W-1:0] ent_q, ent_d;
    logic [CNT_W-1:0]              occ_q, occ_d;
    logic                          iv_q, iv_d;
    logic [ENTRY_W-1:0]            ie_q, ie_d;
    logic [1:0]                    cnt_q, cnt_d;

    logic [DEPTH-1:0]              w_r1, w_r2, req;
    logic [DEPTH-1:0][ENTRY_W-1:0] w_ent;
    logic [ENTRY_W-1:0]            d_ent;
    logic                          d_r1, d_r2;
    logic                          cdb_hit, found, reg_free;
    logic                          do_issue, do_disp;
    logic [IDX_W-1:0]              sel;
    logic [CNT_W-1:0]              wpos;

    assign dispatch_ready = occ_q < CNT_W'(DEPTH);
    assign issue_valid    = iv_q;
    assign issue_entry    = ie_q;
    assign occupancy      = occ_q;

    assign cdb_hit  = cdb_valid && (cdb_tag != PHYS_ZERO);
    assign req      = vld_q & r1_q & r2_q;
    assign reg_free = !iv_q || !issue_stall;
    assign do_issue = found && reg_free;
    assign do_disp  = dispatch_valid && dispatch_ready && !flush;
    assign wpos     = do_issue ? occ_q - 1'b1 : occ_q;

    iq_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_sel (
        .req   (req),
        .found (found),
        .idx   (sel)
    );

    // CDB wakeup of stored slots and of the incoming dispatch.
    always_comb begin
        w_ent = ent_q;
        w_r1  = r1_q;
        w_r2  = r2_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (cdb_hit && !r1_q[i] &&
                ent_q[i][RS1_MSB:RS1_LSB] == cdb_tag) begin
                w_ent[i][RS1V_MSB:RS1V_LSB] = cdb_value;
                w_r1[i] = 1'b1;
            end
            if (cdb_hit && !r2_q[i] &&
                ent_q[i][RS2_MSB:RS2_LSB] == cdb_tag) begin
                w_ent[i][RS2V_MSB:RS2V_LSB] = cdb_value;
                w_r2[i] = 1'b1;
            end
        end
        d_ent = dispatch_entry;
        d_r1  = dispatch_rs1_ready ||
                dispatch_entry[RS1_MSB:RS1_LSB] == PHYS_ZERO;
        d_r2  = dispatch_rs2_ready ||
                dispatch_entry[RS2_MSB:RS2_LSB] == PHYS_ZERO;
        if (cdb_hit && !d_r1 &&
            dispatch_entry[RS1_MSB:RS1_LSB] == cdb_tag) begin
            d_ent[RS1V_MSB:RS1V_LSB] = cdb_value;
            d_r1 = 1'b1;
        end
        if (cdb_hit && !d_r2 &&
            dispatch_entry[RS2_MSB:RS2_LSB] == cdb_tag) begin
            d_ent[RS2V_MSB:RS2V_LSB] = cdb_value;
            d_r2 = 1'b1;
        end
    end

    // Next state: collapse on issue, append dispatch, load issue reg.
    always_comb begin
        vld_d = vld_q;
        r1_d  = w_r1;
        r2_d  = w_r2;
        ent_d = w_ent;
        occ_d = occ_q;
        iv_d  = iv_q;
        ie_d  = ie_q;
        cnt_d = cnt_q;
        if (flush) begin
            vld_d = '0;
            r1_d  = '0;
            r2_d  = '0;
            occ_d = '0;
            iv_d  = 1'b0;
            cnt_d = '0;
        end else begin
            if (do_issue) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if (IDX_W'(i) >= sel) begin
                        vld_d[i] = vld_q[i+1];
                        r1_d[i]  = w_r1[i+1];
                        r2_d[i]  = w_r2[i+1];
                        ent_d[i] = w_ent[i+1];
                    end
                end
                vld_d[DEPTH-1] = 1'b0;
                r1_d[DEPTH-1]  = 1'b0;
                r2_d[DEPTH-1]  = 1'b0;
            end
            if (do_disp) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CNT_W'(i) == wpos) begin
                        vld_d[i] = 1'b1;
                        r1_d[i]  = d_r1;
                        r2_d[i]  = d_r2;
                        ent_d[i] = d_ent;
                    end
                end
            end
            occ_d = occ_q + CNT_W'(do_disp) - CNT_W'(do_issue);
            if (do_issue) begin
                ie_d  = {ent_q[sel][ENTRY_W-1:FU_MSB+1], cnt_q};
                iv_d  = 1'b1;
                cnt_d = cnt_q + 2'd1;
            end else if (reg_free) begin
                iv_d = 1'b0;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            r1_q  <= '0;
            r2_q  <= '0;
            ent_q <= '0;
            occ_q <= '0;
            iv_q  <= 1'b0;
            ie_q  <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            r1_q  <= r1_d;
            r2_q  <= r2_d;
            ent_q <= ent_d;
            occ_q <= occ_d;
            iv_q  <= iv_d;
            ie_q  <= ie_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed checks of dispatch, wakeup, select,
// stall, full-queue and flush behaviour.
module tb_issue_queue;
    import iq_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               flush = 1'b0;
    logic               dispatch_valid = 1'b0;
    logic [ENTRY_W-1:0] dispatch_entry = '0;
    logic               dispatch_rs1_ready = 1'b0;
    logic               dispatch_rs2_ready = 1'b0;
    logic               dispatch_ready;
    logic               cdb_valid = 1'b0;
    logic [TAG_W-1:0]   cdb_tag = '0;
    logic [31:0]        cdb_value = '0;
    logic               issue_stall = 1'b0;
    logic               issue_valid;
    logic [ENTRY_W-1:0] issue_entry;
    logic [3:0]         occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ENTRY_W-1:0] exp_e;

    issue_queue #(.DEPTH(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .dispatch_valid     (dispatch_valid),
        .dispatch_entry     (dispatch_entry),
        .dispatch_rs1_ready (dispatch_rs1_ready),
        .dispatch_rs2_ready (dispatch_rs2_ready),
        .dispatch_ready     (dispatch_ready),
        .cdb_valid          (cdb_valid),
        .cdb_tag            (cdb_tag),
        .cdb_value          (cdb_value),
        .issue_stall        (issue_stall),
        .issue_valid        (issue_valid),
        .issue_entry        (issue_entry),
        .occupancy          (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [ENTRY_W-1:0] got,
                         input logic [ENTRY_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ENTRY_W-1:0] mk(
        input logic [5:0] rob, input logic [5:0] rs1,
        input logic [5:0] rs2);
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[F3_MSB:F3_LSB]     = rob[2:0];
        e[F7_MSB:F7_LSB]     = 7'h2A;
        e[OPC_MSB:OPC_LSB]   = 7'h33;
        e[RD_MSB:RD_LSB]     = rob + 6'd1;
        e[RS1_MSB:RS1_LSB]   = rs1;
        e[RS1V_MSB:RS1V_LSB] = 32'h1000_0000 | 32'(rob);
        e[RS2_MSB:RS2_LSB]   = rs2;
        e[RS2V_MSB:RS2V_LSB] = 32'h2000_0000 | 32'(rob);
        e[IMM_MSB:IMM_LSB]   = 32'hA000_0000 | 32'(rob);
        e[ROB_MSB:ROB_LSB]   = rob;
        e[FU_MSB:FU_LSB]     = 2'b11;
        return e;
    endfunction

    function automatic logic [ENTRY_W-1:0] with_fu(
        input logic [ENTRY_W-1:0] e, input logic [1:0] fu);
        logic [ENTRY_W-1:0] r;
        r = e;
        r[FU_MSB:FU_LSB] = fu;
        return r;
    endfunction

    task automatic drive(input logic [ENTRY_W-1:0] e,
                         input logic r1, input logic r2);
        dispatch_valid     = 1'b1;
        dispatch_entry     = e;
        dispatch_rs1_ready = r1;
        dispatch_rs2_ready = r2;
    endtask

    task automatic idle();
        dispatch_valid     = 1'b0;
        dispatch_rs1_ready = 1'b0;
        dispatch_rs2_ready = 1'b0;
        cdb_valid          = 1'b0;
        flush              = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (2) tick();
        check("rst_iv", 139'(issue_valid), 139'(0));
        check("rst_ie", issue_entry, '0);
        check("rst_occ", 139'(occupancy), 139'(0));
        check("rst_dr", 139'(dispatch_ready), 139'(1));
        rst = 1'b0;
        tick();

        // single ready dispatch issues one edge later
        drive(mk(6'd5, 6'd1, 6'd2), 1'b1, 1'b1);
        tick();
        idle();
        check("t1_occ1", 139'(occupancy), 139'(1));
        check("t1_iv0", 139'(issue_valid), 139'(0));
        tick();
        check("t1_iv", 139'(issue_valid), 139'(1));
        check("t1_ie", issue_entry, with_fu(mk(6'd5, 6'd1, 6'd2), 2'd0));
        check("t1_occ0", 139'(occupancy), 139'(0));
        tick();
        check("t1_drop", 139'(issue_valid), 139'(0));

        // younger ready entry bypasses an older waiting one
        drive(mk(6'd6, 6'd12, 6'd3), 1'b0, 1'b1);
        tick();
        drive(mk(6'd7, 6'd4, 6'd3), 1'b1, 1'b1);
        tick();
        idle();
        check("t2_occ2", 139'(occupancy), 139'(2));
        tick();
        check("t2_b", issue_entry, with_fu(mk(6'd7, 6'd4, 6'd3), 2'd1));
        check("t2_biv", 139'(issue_valid), 139'(1));
        cdb_valid = 1'b1;
        cdb_tag   = 6'd12;
        cdb_value = 32'hDEAD_BEEF;
        tick();
        idle();
        check("t2_wiv", 139'(issue_valid), 139'(0));
        tick();
        exp_e = with_fu(mk(6'd6, 6'd12, 6'd3), 2'd2);
        exp_e[RS1V_MSB:RS1V_LSB] = 32'hDEAD_BEEF;
        check("t2_a", issue_entry, exp_e);
        check("t2_aiv", 139'(issue_valid), 139'(1));
        check("t2_occ", 139'(occupancy), 139'(0));
        tick();

        // fill to full, overflow dropped, wake slot 3
        for (int i = 0; i < 8; i++) begin
            drive(mk(6'(10 + i), 6'(20 + i), 6'd0), 1'b0, 1'b0);
            tick();
        end
        idle();
        check("t3_full", 139'(occupancy), 139'(8));
        check("t3_dr0", 139'(dispatch_ready), 139'(0));
        drive(mk(6'd62, 6'd1, 6'd1), 1'b1, 1'b1);
        tick();
        idle();
        check("t3_drop", 139'(occupancy), 139'(8));
        check("t3_noiss", 139'(issue_valid), 139'(0));
        cdb_valid = 1'b1;
        cdb_tag   = 6'd23;
        cdb_value = 32'hCAFE_0003;
        tick();
        idle();
        check("t3_wocc", 139'(occupancy), 139'(8));
        drive(mk(6'd61, 6'd1, 6'd1), 1'b1, 1'b1);
        tick();
        idle();
        exp_e = with_fu(mk(6'd13, 6'd23, 6'd0), 2'd3);
        exp_e[RS1V_MSB:RS1V_LSB] = 32'hCAFE_0003;
        check("t3_s3", issue_entry, exp_e);
        check("t3_s3iv", 139'(issue_valid), 139'(1));
        check("t3_occ7", 139'(occupancy), 139'(7));
        check("t3_dr1", 139'(dispatch_ready), 139'(1));

        // flush from a busy state
        flush = 1'b1;
        tick();
        idle();
        check("f0_occ", 139'(occupancy), 139'(0));
        check("f0_iv", 139'(issue_valid), 139'(0));

        drive(mk(6'd30, 6'd1, 6'd1), 1'b1, 1'b1);
        tick();
        issue_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(mk(6'(31 + i), 6'd30, 6'd0), 1'b0, 1'b0);
            tick();
        end
        idle();
        check("f1_occ5", 139'(occupancy), 139'(5));
        check("f1_iv", 139'(issue_valid), 139'(1));
        flush = 1'b1;
        drive(mk(6'd36, 6'd1, 6'd1), 1'b1, 1'b1);
        tick();
        idle();
        issue_stall = 1'b0;
        check("f1_occ0", 139'(occupancy), 139'(0));
        check("f1_iv0", 139'(issue_valid), 139'(0));
        cdb_valid = 1'b1;
        cdb_tag   = 6'd30;
        cdb_value = 32'h1;
        tick();
        idle();
        tick();
        check("f1_quiet", 139'(issue_valid), 139'(0));
        check("f1_qocc", 139'(occupancy), 139'(0));

        // stall holds the issue register, release drains in order
        drive(mk(6'd40, 6'd1, 6'd2), 1'b1, 1'b1);
        tick();
        idle();
        tick();
        check("s_first", issue_entry, with_fu(mk(6'd40, 6'd1, 6'd2), 2'd0));
        issue_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(mk(6'(41 + i), 6'd1, 6'd2), 1'b1, 1'b1);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s_hold", issue_entry,
                  with_fu(mk(6'd40, 6'd1, 6'd2), 2'd0));
            check("s_occ", 139'(occupancy), 139'(3));
            check("s_iv", 139'(issue_valid), 139'(1));
        end
        issue_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s_drain", issue_entry,
                  with_fu(mk(6'(41 + i), 6'd1, 6'd2), 2'(1 + i)));
            check("s_div", 139'(issue_valid), 139'(1));
        end
        check("s_occ0", 139'(occupancy), 139'(0));

        // wakeup in the dispatch cycle, phys 0 forced ready
        drive(mk(6'd50, 6'd0, 6'd9), 1'b0, 1'b0);
        cdb_valid = 1'b1;
        cdb_tag   = 6'd9;
        cdb_value = 32'h1234_5678;
        tick();
        idle();
        check("w_occ", 139'(occupancy), 139'(1));
        tick();
        exp_e = with_fu(mk(6'd50, 6'd0, 6'd9), 2'd0);
        exp_e[RS2V_MSB:RS2V_LSB] = 32'h1234_5678;
        check("w_same", issue_entry, exp_e);
        check("w_iv", 139'(issue_valid), 139'(1));

        // tag 0 broadcast never wakes; real tag does
        drive(mk(6'd51, 6'd5, 6'd0), 1'b0, 1'b0);
        tick();
        idle();
        cdb_valid = 1'b1;
        cdb_tag   = 6'd0;
        cdb_value = 32'h0000_0077;
        tick();
        tick();
        check("z_iv", 139'(issue_valid), 139'(0));
        check("z_occ", 139'(occupancy), 139'(1));
        cdb_tag   = 6'd5;
        cdb_value = 32'h0000_0055;
        tick();
        idle();
        tick();
        exp_e = with_fu(mk(6'd51, 6'd5, 6'd0), 2'd1);
        exp_e[RS1V_MSB:RS1V_LSB] = 32'h0000_0055;
        check("z_wake", issue_entry, exp_e);
        check("z_wiv", 139'(issue_valid), 139'(1));

        // asynchronous reset mid-operation
        drive(mk(6'd52, 6'd1, 6'd1), 1'b1, 1'b1);
        tick();
        idle();
        #2 rst = 1'b1;
        #1;
        check("ar_occ", 139'(occupancy), 139'(0));
        check("ar_iv", 139'(issue_valid), 139'(0));
        check("ar_ie", issue_entry, '0);
        tick();
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
# issue_queue

In-order-age issue queue feeding the functional unit. Renamed instructions arrive as 139-bit entries from dispatch with per-operand ready bits. Source operands wake up from the common data bus (CDB) broadcast. Each cycle the oldest entry with both operands ready is selected and presented, registered, on the FU-side entry bus with an `enable`-style valid.

## Interface
- `DEPTH`, 8: number of queue slots, 2..32.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear of all slots and the issue register.
- `dispatch_valid` in 1: `dispatch_entry` is offered this cycle.
- `dispatch_entry` in 139: funct3[138:136], funct7[135:129], opcode[128:122], phys_rd[121:116], phys_rs1[115:110], rs1_val[109:78], phys_rs2[77:72], rs2_val[71:40], imm[39:8], rob_idx[7:2], fu_cnt[1:0].
- `dispatch_rs1_ready`, `dispatch_rs2_ready` in 1 each: operand value in the entry is already valid.
- `dispatch_ready` out 1: queue accepts a dispatch this cycle.
- `cdb_valid` in 1, `cdb_tag` in 6, `cdb_value` in 32: result broadcast.
- `issue_stall` in 1: FU cannot accept; hold the issue register.
- `issue_valid` out 1: drives the FU `enable`.
- `issue_entry` out 139: entry to the FU, same layout as `dispatch_entry`.
- `occupancy` out clog2(DEPTH+1): valid slot count.

## Operation
- Storage is a collapsing queue: slot 0 is oldest and valid slots are contiguous from 0. Per slot it holds a valid bit, the 139-bit entry, rs1_rdy and rs2_rdy.
- `dispatch_ready = (occupancy < DEPTH)`. The combinational path depends on count only, never on the same-cycle issue.
- A dispatch is accepted when `dispatch_valid && dispatch_ready && !flush`.
  - It is written to slot `occupancy`, or to `occupancy-1` if an issue shift occurs in the same cycle.
  - `dispatch_valid` while not ready is dropped; no state changes.
- Wakeup: for every valid slot and for the entry being dispatched this cycle, when `cdb_valid` is high, `cdb_tag != 0` and a not-ready phys_rs1 (or rs2) equals `cdb_tag`:
  - write `cdb_value` into rs1_val (or rs2_val);
  - set the matching ready bit.
  - Both operands may wake on the same broadcast.
- phys reg 0 is always ready: a dispatch with phys_rs1 or phys_rs2 equal to 0 forces that ready bit to 1.
- Select: the lowest-index valid slot with rs1_rdy && rs2_rdy, using ready bits as registered (no same-cycle wakeup-to-select).
- Issue occurs when a slot is selected and the issue register is free: `!issue_valid || !issue_stall`.
  - The issue register loads the selected entry with fu_cnt[1:0] replaced by the 2-bit issue counter.
  - `issue_valid` is set to 1 and the counter increments, wrapping 3→0.
  - Slots above the issued slot shift down by one.
- No issue this cycle while the register is free: `issue_valid` goes 0 and `issue_entry` holds its last value.
- While stalled: `issue_valid`/`issue_entry` hold; wakeup and dispatch continue.
- `flush`: clears all slot valids, `occupancy`, `issue_valid` and the issue counter. Same-cycle dispatch, issue and wakeup are discarded. Priority: rst > flush > normal operation.

## Timing
- Reset values:
  - `issue_valid`=0, `issue_entry`=0, `occupancy`=0, `dispatch_ready`=1, issue counter=0;
  - all slot valid bits and ready bits = 0.
- Latency from dispatch with both operands ready (edge E) to `issue_valid`=1: one edge later, E+1. That is one cycle residency, two cycles from dispatch request to FU enable.
- Latency from a CDB match at edge W to issue: edge W+1 at the earliest.
- Full queue with simultaneous issue: `dispatch_ready`=0 this cycle and the dispatch is refused. A slot frees at the edge, so `dispatch_ready`=1 next cycle.
- Empty queue, or no ready entry with the register free: `issue_valid`=0 after the edge.
- Reset asserted mid-operation clears everything immediately and asynchronously. No partial shift survives.

## Structure
- Shared package `iq_pkg`:
  - entry width 139;
  - bit-position localparams for every field (also consumed by the functional unit);
  - a tag width of 6;
  - the constant `PHYS_ZERO`=0.
- One sub-module, `iq_select`: a DEPTH-wide lowest-index priority encoder producing a found flag and an index. Wakeup compare, shift and the issue register live in `issue_queue`.

## Test plan
- Reset, then dispatch one entry with both ready, rob_idx=5 → `issue_valid`=1 one edge later. `issue_entry[7:2]`=5, fu_cnt=0, `occupancy` returns to 0.
- Dispatch A (rs1 tag 12, not ready) then B (ready) → B issues first. Broadcast tag 12 with value 0xDEADBEEF → A issues on the following edge with `issue_entry[109:78]`=0xDEADBEEF.
- Fill 8 entries with none ready → `dispatch_ready`=0 and a ninth dispatch is dropped. Broadcast the tag of slot 3 → slot 3 issues, `occupancy`=7, `dispatch_ready`=1.
- Hold `issue_stall`=1 with 3 ready entries for 4 cycles → `issue_entry` constant and `occupancy` stays 3. Release → the entries issue in dispatch order over 3 consecutive cycles, fu_cnt 1,2,3 after a prior issue left the counter at 1.
- Dispatch with rs2 tag 9 in the same cycle as CDB tag 9 → the entry is stored ready and issues one edge later. CDB tag 0 never wakes an entry.
- Queue of 5 entries with `issue_valid`=1, assert `flush` together with `dispatch_valid` → next cycle `occupancy`=0, `issue_valid`=0, no issue until a new dispatch.
